// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register file.
// Build option AXIL_REGFILE_SLVERR_EN selects SLVERR (instead of OKAY) for out-of-range accesses.
package axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_t;

   localparam int MAX_DATA_W = 64;
   localparam int MAX_STRB_W = MAX_DATA_W / 8;

`ifdef AXIL_REGFILE_SLVERR_EN
   localparam axi_resp_t OOR_RESP = SLVERR;
`else
   localparam axi_resp_t OOR_RESP = OKAY;
`endif

   // Byte offset bits dropped from an address to form the word index.
   function automatic int addr_lsb(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   // Narrower buses zero-extend into the 64-bit form and take the low bits back.
   function automatic logic [MAX_DATA_W-1:0] strb_merge(
      input logic [MAX_DATA_W-1:0] old_d,
      input logic [MAX_DATA_W-1:0] new_d,
      input logic [MAX_STRB_W-1:0] strb
   );
      logic [MAX_DATA_W-1:0] merged;
      merged = old_d;
      for (int k = 0; k < MAX_STRB_W; k++) begin
         if (strb[k]) merged[k*8 +: 8] = new_d[k*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axil_regfile_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axil_regfile_if
   import axil_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   axi_resp_t           bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   axi_resp_t           rresp;
   logic                rvalid;
   logic                rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awprot, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axil_regfile_rd.sv
// Read channel of the register file: AR/R handshake, index decode and registered read mux.
// Out-of-range response code follows AXIL_REGFILE_SLVERR_EN through axil_pkg.
module axil_regfile_rd
   import axil_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int NUM_REGS = 4
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [ADDR_W-1:0]          araddr,
   input  logic                       arvalid,
   output logic                       arready,
   output logic [DATA_W-1:0]          rdata,
   output axi_resp_t                  rresp,
   output logic                       rvalid,
   input  logic                       rready,
   input  logic [NUM_REGS*DATA_W-1:0] reg_q
);
   localparam int ADDR_LSB = addr_lsb(DATA_W);

   logic              ar_fire;
   logic [ADDR_W-1:0] rd_word;
   logic              rd_in_range;
   logic [DATA_W-1:0] rd_mux;

   assign arready     = !areset && !rvalid;
   assign ar_fire     = arvalid && arready;
   assign rd_word     = araddr >> ADDR_LSB;
   assign rd_in_range = rd_word < ADDR_W'(NUM_REGS);

   // NOTE: rd_mux gets a default before the loop so no path leaves it unassigned (no latch).
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_word == ADDR_W'(i)) rd_mux = reg_q[i*DATA_W +: DATA_W];
      end
   end

   // reg_q is the registered state, so a same-edge write is seen only by later reads.
   always_ff @(posedge aclk) begin
      if (areset) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= OKAY;
      end else if (ar_fire) begin
         rvalid <= 1'b1;
         rdata  <= rd_mux;
         rresp  <= rd_in_range ? OKAY : OOR_RESP;
      end else if (rvalid && rready) begin
         rvalid <= 1'b0;
      end
   end
endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave register file: independent AW/W capture, byte strobes, per-register write pulse.
// Build option AXIL_REGFILE_SLVERR_EN: out-of-range accesses respond SLVERR instead of OKAY.
module axil_regfile
   import axil_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int NUM_REGS = 4
) (
   input  logic                       aclk,
   input  logic                       areset,
   axil_regfile_if.slave              s_axi,
   output logic [NUM_REGS*DATA_W-1:0] reg_q,
   output logic [NUM_REGS-1:0]        wr_pulse
);
   localparam int STRB_W   = DATA_W / 8;
   localparam int ADDR_LSB = addr_lsb(DATA_W);

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              aw_pend;
   logic              w_pend;
   logic              bvalid;
   axi_resp_t         bresp;
   logic [ADDR_W-1:0] aw_addr_q;
   logic [DATA_W-1:0] w_data_q;
   logic [STRB_W-1:0] w_strb_q;

   logic              aw_fire;
   logic              w_fire;
   logic              commit;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] wr_word;
   logic [DATA_W-1:0] wr_data;
   logic [STRB_W-1:0] wr_strb;
   logic              wr_in_range;
   logic              unused_prot;

   assign s_axi.awready = !areset && !aw_pend && !bvalid;
   assign s_axi.wready  = !areset && !w_pend && !bvalid;
   assign s_axi.bvalid  = bvalid;
   assign s_axi.bresp   = bresp;
   assign unused_prot   = ^{s_axi.awprot, s_axi.arprot};

   assign aw_fire = s_axi.awvalid && s_axi.awready;
   assign w_fire  = s_axi.wvalid && s_axi.wready;
   assign commit  = (aw_pend || aw_fire) && (w_pend || w_fire);

   // Buffered beat wins; otherwise the beat handshaking this cycle is used directly.
   assign wr_addr     = aw_pend ? aw_addr_q : s_axi.awaddr;
   assign wr_data     = w_pend ? w_data_q : s_axi.wdata;
   assign wr_strb     = w_pend ? w_strb_q : s_axi.wstrb;
   assign wr_word     = wr_addr >> ADDR_LSB;
   assign wr_in_range = wr_word < ADDR_W'(NUM_REGS);

   // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
   // NOTE: the registers are reset because downstream control logic consumes reg_q directly.
   always_ff @(posedge aclk) begin
      if (areset) begin
         aw_pend   <= 1'b0;
         w_pend    <= 1'b0;
         bvalid    <= 1'b0;
         bresp     <= OKAY;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         wr_pulse  <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         wr_pulse <= '0;
         if (commit) begin
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_in_range ? OKAY : OOR_RESP;
            for (int i = 0; i < NUM_REGS; i++) begin
               if (wr_in_range && wr_word == ADDR_W'(i)) begin
                  regs[i]     <= DATA_W'(strb_merge(MAX_DATA_W'(regs[i]), MAX_DATA_W'(wr_data),
                                                    MAX_STRB_W'(wr_strb)));
                  wr_pulse[i] <= 1'b1;
               end
            end
         end else begin
            if (aw_fire) begin
               aw_pend   <= 1'b1;
               aw_addr_q <= s_axi.awaddr;
            end
            if (w_fire) begin
               w_pend   <= 1'b1;
               w_data_q <= s_axi.wdata;
               w_strb_q <= s_axi.wstrb;
            end
            if (bvalid && s_axi.bready) bvalid <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
      assign reg_q[i*DATA_W +: DATA_W] = regs[i];
   end

   axil_regfile_rd #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS)
   ) u_rd (
      .aclk    (aclk),
      .areset  (areset),
      .araddr  (s_axi.araddr),
      .arvalid (s_axi.arvalid),
      .arready (s_axi.arready),
      .rdata   (s_axi.rdata),
      .rresp   (s_axi.rresp),
      .rvalid  (s_axi.rvalid),
      .rready  (s_axi.rready),
      .reg_q   (reg_q)
   );
endmodule

// File: tb/tb_axil_regfile.sv
// Self-checking bench for axil_regfile (NUM_REGS=4, DATA_W=32) against an array-based register model.
module tb_axil_regfile;
   logic         aclk = 1'b0;
   logic         areset;
   logic [127:0] reg_q;
   logic [3:0]   wr_pulse;
   int           n_checks = 0;
   int           n_fails  = 0;
   logic [31:0]  model [4];
   logic [1:0]   exp_oor;

   axil_regfile_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   axil_regfile #(.DATA_W(32), .ADDR_W(32), .NUM_REGS(4)) dut (
      .aclk     (aclk),
      .areset   (areset),
      .s_axi    (bus.slave),
      .reg_q    (reg_q),
      .wr_pulse (wr_pulse)
   );

   always #5 aclk = ~aclk;

   task automatic cyc();
      @(posedge aclk);
      @(negedge aclk);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [127:0] model_flat();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb);
      logic [31:0] idx;
      idx = addr / 4;
      if (idx < 4) begin
         for (int k = 0; k < 4; k++)
            if (strb[k]) model[idx[1:0]][k*8 +: 8] = data[k*8 +: 8];
      end
   endfunction

   function automatic logic [3:0] exp_pulse(input logic [31:0] addr);
      logic [31:0] idx;
      idx = addr / 4;
      return (idx < 4) ? (4'b0001 << idx[1:0]) : 4'b0000;
   endfunction

   function automatic logic [1:0] exp_resp(input logic [31:0] addr);
      return (addr / 4 < 4) ? 2'b00 : exp_oor;
   endfunction

   function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
      logic [31:0] idx;
      idx = addr / 4;
      return (idx < 4) ? model[idx[1:0]] : 32'h0;
   endfunction

   // ---------------- bus drivers ----------------
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output logic [3:0] pulse);
      bit aw_done = 0;
      bit w_done  = 0;
      bit aw_hs, w_hs;
      int c = 0;
      bus.awaddr = addr;
      bus.wdata  = data;
      bus.wstrb  = strb;
      while (!(aw_done && w_done) && c < 40) begin
         bus.awvalid = !aw_done && (c >= aw_dly);
         bus.wvalid  = !w_done && (c >= w_dly);
         #1;
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         cyc();
         aw_done = aw_done | aw_hs;
         w_done  = w_done | w_hs;
         c++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      c = 0;
      while (!bus.bvalid && c < 20) begin
         cyc();
         c++;
      end
      n_checks++;
      if (!bus.bvalid) begin
         n_fails++;
         $display("FAIL write_timeout addr=%h bvalid got 0 exp 1", addr);
         resp  = 2'bxx;
         pulse = 4'bxxxx;
      end else begin
         resp  = bus.bresp;
         pulse = wr_pulse;
         bus.bready = 1'b1;
         cyc();
         bus.bready = 1'b0;
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      bit hs = 0;
      int c = 0;
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      while (!hs && c < 20) begin
         #1 hs = bus.arready;
         cyc();
         c++;
      end
      bus.arvalid = 1'b0;
      n_checks++;
      if (!bus.rvalid) begin
         n_fails++;
         $display("FAIL read_timeout addr=%h rvalid got 0 exp 1", addr);
         data = 'x;
         resp = 'x;
      end else begin
         data = bus.rdata;
         resp = bus.rresp;
         bus.rready = 1'b1;
         cyc();
         bus.rready = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      areset = 1'b1;
      repeat (3) cyc();
      for (int i = 0; i < 4; i++) model[i] = '0;
      n_checks++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin n_fails++; $display("FAIL reset_valids got %b exp 00", {bus.bvalid, bus.rvalid}); end
      n_checks++; if (reg_q !== 128'h0) begin n_fails++; $display("FAIL reset_reg_q got %h exp 0", reg_q); end
      n_checks++; if (wr_pulse !== 4'h0) begin n_fails++; $display("FAIL reset_pulse got %b exp 0000", wr_pulse); end
      n_checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin n_fails++; $display("FAIL reset_readies_in_reset got %b exp 000", {bus.awready, bus.wready, bus.arready}); end
      n_checks++; if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin n_fails++; $display("FAIL reset_resp_rdata got %h exp 0", {bus.bresp, bus.rresp, bus.rdata}); end
      areset = 1'b0;
      #1;
      n_checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin n_fails++; $display("FAIL reset_readies_after got %b exp 111", {bus.awready, bus.wready, bus.arready}); end
      @(negedge aclk);
   endtask

   task automatic test_basic_write();
      bus.awaddr = 32'h4; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
      #1;
      n_checks++; if ({bus.awready, bus.wready} !== 2'b11) begin n_fails++; $display("FAIL basic_ready got %b exp 11", {bus.awready, bus.wready}); end
      cyc();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      model_write(32'h4, 32'hDEADBEEF, 4'hF);
      n_checks++; if (bus.bvalid !== 1'b1) begin n_fails++; $display("FAIL basic_bvalid got %b exp 1", bus.bvalid); end
      n_checks++; if (bus.bresp !== 2'b00) begin n_fails++; $display("FAIL basic_bresp got %b exp 00", bus.bresp); end
      n_checks++; if (reg_q[63:32] !== 32'hDEADBEEF) begin n_fails++; $display("FAIL basic_reg1 got %h exp deadbeef", reg_q[63:32]); end
      n_checks++; if (wr_pulse !== 4'b0010) begin n_fails++; $display("FAIL basic_pulse got %b exp 0010", wr_pulse); end
      bus.bready = 1'b1;
      cyc();
      bus.bready = 1'b0;
      n_checks++; if (wr_pulse !== 4'b0000) begin n_fails++; $display("FAIL basic_pulse_width got %b exp 0000", wr_pulse); end
      n_checks++; if (bus.bvalid !== 1'b0) begin n_fails++; $display("FAIL basic_bvalid_clear got %b exp 0", bus.bvalid); end
      n_checks++; if (reg_q !== model_flat()) begin n_fails++; $display("FAIL basic_reg_q got %h exp %h", reg_q, model_flat()); end
   endtask

   task automatic test_strobe();
      logic [1:0]  resp;
      logic [3:0]  pulse;
      logic [31:0] data;
      axi_write(32'h0, 32'h11223344, 4'hF, 0, 0, resp, pulse);
      model_write(32'h0, 32'h11223344, 4'hF);
      axi_write(32'h0, 32'hAABBCCDD, 4'b0101, 0, 0, resp, pulse);
      model_write(32'h0, 32'hAABBCCDD, 4'b0101);
      n_checks++; if (reg_q[31:0] !== 32'h11BB33DD) begin n_fails++; $display("FAIL strobe_reg0 got %h exp 11bb33dd", reg_q[31:0]); end
      axi_read(32'h0, data, resp);
      n_checks++; if (data !== 32'h11BB33DD) begin n_fails++; $display("FAIL strobe_read got %h exp 11bb33dd", data); end
      axi_write(32'h0, 32'hFFFFFFFF, 4'h0, 0, 0, resp, pulse);
      n_checks++; if (pulse !== 4'b0001) begin n_fails++; $display("FAIL strobe_zero_pulse got %b exp 0001", pulse); end
      n_checks++; if (reg_q !== model_flat()) begin n_fails++; $display("FAIL strobe_zero_data got %h exp %h", reg_q, model_flat()); end
   endtask

   task automatic test_ordering();
      logic [31:0] data;
      for (int order = 0; order < 2; order++) begin
         data = (order == 0) ? 32'h12345678 : 32'h0BADF00D;
         bus.awaddr = 32'h8; bus.wdata = data; bus.wstrb = 4'hF;
         if (order == 0) bus.wvalid = 1'b1; else bus.awvalid = 1'b1;
         cyc();
         bus.wvalid = 1'b0; bus.awvalid = 1'b0;
         #1;
         n_checks++; if ((order == 0 ? bus.wready : bus.awready) !== 1'b0) begin n_fails++; $display("FAIL order%0d_ready_after_first got 1 exp 0", order); end
         repeat (2) cyc();
         n_checks++; if (bus.bvalid !== 1'b0) begin n_fails++; $display("FAIL order%0d_early_bvalid got 1 exp 0", order); end
         if (order == 0) bus.awvalid = 1'b1; else bus.wvalid = 1'b1;
         cyc();
         bus.wvalid = 1'b0; bus.awvalid = 1'b0;
         model_write(32'h8, data, 4'hF);
         n_checks++; if (bus.bvalid !== 1'b1) begin n_fails++; $display("FAIL order%0d_bvalid got 0 exp 1", order); end
         n_checks++; if (reg_q[95:64] !== data) begin n_fails++; $display("FAIL order%0d_reg2 got %h exp %h", order, reg_q[95:64], data); end
         n_checks++; if (wr_pulse !== 4'b0100) begin n_fails++; $display("FAIL order%0d_pulse got %b exp 0100", order, wr_pulse); end
         bus.bready = 1'b1;
         cyc();
         bus.bready = 1'b0;
      end
   endtask

   task automatic test_backpressure();
      bus.awaddr = 32'h4; bus.wdata = 32'hCAFE0001; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
      cyc();
      model_write(32'h4, 32'hCAFE0001, 4'hF);
      bus.awaddr = 32'hC; bus.wdata = 32'h00000077;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== 5'b10000) begin n_fails++; $display("FAIL bp_hold_cycle%0d got %b exp 10000", i, {bus.bvalid, bus.bresp, bus.awready, bus.wready}); end
         n_checks++; if (reg_q !== model_flat()) begin n_fails++; $display("FAIL bp_no_second_write got %h exp %h", reg_q, model_flat()); end
         cyc();
      end
      bus.bready = 1'b1;
      cyc();
      bus.bready = 1'b0;
      #1;
      n_checks++; if ({bus.bvalid, bus.awready} !== 2'b01) begin n_fails++; $display("FAIL bp_release got %b exp 01", {bus.bvalid, bus.awready}); end
      cyc();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      model_write(32'hC, 32'h00000077, 4'hF);
      n_checks++; if ({bus.bvalid, wr_pulse} !== 5'b11000) begin n_fails++; $display("FAIL bp_second_commit got %b exp 11000", {bus.bvalid, wr_pulse}); end
      n_checks++; if (reg_q !== model_flat()) begin n_fails++; $display("FAIL bp_second_data got %h exp %h", reg_q, model_flat()); end
      bus.bready = 1'b1;
      cyc();
      bus.bready = 1'b0;
   endtask

   task automatic test_out_of_range();
      logic [1:0]  resp;
      logic [3:0]  pulse;
      logic [31:0] data;
      axi_write(32'h10, 32'hFFFFFFFF, 4'hF, 0, 0, resp, pulse);
      n_checks++; if (resp !== exp_oor) begin n_fails++; $display("FAIL oor_wr_resp got %b exp %b", resp, exp_oor); end
      n_checks++; if (pulse !== 4'b0000) begin n_fails++; $display("FAIL oor_wr_pulse got %b exp 0000", pulse); end
      n_checks++; if (reg_q !== model_flat()) begin n_fails++; $display("FAIL oor_wr_data got %h exp %h", reg_q, model_flat()); end
      axi_read(32'h10, data, resp);
      n_checks++; if ({data, resp} !== {32'h0, exp_oor}) begin n_fails++; $display("FAIL oor_rd got %h/%b exp 0/%b", data, resp, exp_oor); end
      axi_read(32'h13, data, resp);
      n_checks++; if ({data, resp} !== {32'h0, exp_oor}) begin n_fails++; $display("FAIL oor_rd_unaligned got %h/%b exp 0/%b", data, resp, exp_oor); end
   endtask

   task automatic test_read_during_write();
      logic [31:0] old_val;
      logic [31:0] data;
      logic [1:0]  resp;
      logic [3:0]  pulse;
      old_val = model[3];
      bus.araddr = 32'hC; bus.arvalid = 1'b1; bus.rready = 1'b0;
      cyc();
      bus.arvalid = 1'b0;
      axi_write(32'hC, 32'h5, 4'hF, 0, 0, resp, pulse);
      model_write(32'hC, 32'h5, 4'hF);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++; if ({bus.rvalid, bus.arready, bus.rdata} !== {2'b10, old_val}) begin n_fails++; $display("FAIL rdw_hold got %b%b/%h exp 10/%h", bus.rvalid, bus.arready, bus.rdata, old_val); end
         cyc();
      end
      n_checks++; if (reg_q[127:96] !== 32'h5) begin n_fails++; $display("FAIL rdw_reg3 got %h exp 5", reg_q[127:96]); end
      bus.rready = 1'b1;
      cyc();
      bus.rready = 1'b0;
      axi_read(32'hC, data, resp);
      n_checks++; if (data !== 32'h5) begin n_fails++; $display("FAIL rdw_reread got %h exp 5", data); end
   endtask

   task automatic test_same_edge();
      logic [31:0] old_val;
      logic [31:0] new_val;
      old_val = model[0];
      new_val = $urandom;
      bus.araddr = 32'h0; bus.arvalid = 1'b1;
      bus.awaddr = 32'h0; bus.wdata = new_val; bus.wstrb = 4'hF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      cyc();
      bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      model_write(32'h0, new_val, 4'hF);
      n_checks++; if (bus.rdata !== old_val) begin n_fails++; $display("FAIL same_edge_rdata got %h exp %h", bus.rdata, old_val); end
      n_checks++; if (reg_q[31:0] !== new_val) begin n_fails++; $display("FAIL same_edge_reg0 got %h exp %h", reg_q[31:0], new_val); end
      bus.bready = 1'b1; bus.rready = 1'b1;
      cyc();
      bus.bready = 1'b0; bus.rready = 1'b0;
   endtask

   task automatic test_reset_midflight();
      bus.awaddr = 32'h4; bus.wdata = 32'h99; bus.wstrb = 4'hF; bus.awvalid = 1'b1;
      bus.araddr = 32'h4; bus.arvalid = 1'b1;
      cyc();
      bus.awvalid = 1'b0; bus.arvalid = 1'b0;
      areset = 1'b1;
      cyc();
      areset = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;
      bus.bready = 1'b1; bus.rready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready} !== 4'b0011) begin n_fails++; $display("FAIL midreset_state got %b exp 0011", {bus.bvalid, bus.rvalid, bus.awready, bus.wready}); end
         cyc();
      end
      n_checks++; if (reg_q !== 128'h0) begin n_fails++; $display("FAIL midreset_reg_q got %h exp 0", reg_q); end
      bus.bready = 1'b0; bus.rready = 1'b0;
   endtask

   task automatic test_random();
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_d;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [3:0]  pulse;
      for (int it = 0; it < 60; it++) begin
         addr = $urandom_range(0, 23);
         data = $urandom;
         strb = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            axi_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp, pulse);
            model_write(addr, data, strb);
            n_checks++; if (resp !== exp_resp(addr)) begin n_fails++; $display("FAIL rand_wr_resp it=%0d addr=%h got %b exp %b", it, addr, resp, exp_resp(addr)); end
            n_checks++; if (pulse !== exp_pulse(addr)) begin n_fails++; $display("FAIL rand_wr_pulse it=%0d addr=%h got %b exp %b", it, addr, pulse, exp_pulse(addr)); end
            n_checks++; if (reg_q !== model_flat()) begin n_fails++; $display("FAIL rand_wr_data it=%0d got %h exp %h", it, reg_q, model_flat()); end
         end else begin
            exp_d = exp_rdata(addr);
            axi_read(addr, data, resp);
            n_checks++; if ({data, resp} !== {exp_d, exp_resp(addr)}) begin n_fails++; $display("FAIL rand_rd it=%0d addr=%h got %h/%b exp %h/%b", it, addr, data, resp, exp_d, exp_resp(addr)); end
         end
      end
   endtask

   initial begin
`ifdef AXIL_REGFILE_SLVERR_EN
      exp_oor = 2'b10;
`else
      exp_oor = 2'b00;
`endif
      areset      = 1'b1;
      bus.awaddr  = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata   = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
      bus.bready  = 1'b0;
      bus.araddr  = '0; bus.arprot = '0; bus.arvalid = 1'b0;
      bus.rready  = 1'b0;
      @(negedge aclk);
      test_reset();
      test_basic_write();
      test_strobe();
      test_ordering();
      test_backpressure();
      test_out_of_range();
      test_read_during_write();
      test_same_edge();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
